// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular exponentiation engine: FSM state encoding
// and the default operand width.
package mod_exp_pkg;

    localparam int DEFAULT_WIDTH = 512;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        MUL    = 3'd2,
        SQR    = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mod_exp_engine_if.sv
// Operand/result bundle of the modular exponentiation engine, used by the
// requesting side (master) and the engine side (slave).
interface mod_exp_engine_if #(
    parameter int WIDTH     = mod_exp_pkg::DEFAULT_WIDTH,
    parameter int EXP_WIDTH = WIDTH
);
    // Both channels use strict valid/ready: a transfer happens on a rising edge
    // where valid and ready are both 1; a source holds valid and its payload
    // until that edge, and ready may depend on state only, never on valid.
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic [WIDTH-1:0]     modulo;
    logic                 op_valid;
    logic                 op_ready;
    logic [WIDTH-1:0]     c;
    logic                 res_valid;
    logic                 res_ready;
    logic                 busy;
    logic                 error;

    modport master (
        output base, exponent, modulo, op_valid, res_ready,
        input  op_ready, c, res_valid, busy, error
    );

    modport slave (
        input  base, exponent, modulo, op_valid, res_ready,
        output op_ready, c, res_valid, busy, error
    );

endinterface

// File: rtl/mod_mult_serial.sv
// Interleaved MSB-first shift-add modular multiplier: p = (a*b) mod m, one bit
// of a per cycle. Requires b < m and m != 0; a may be any value.
module mod_mult_serial #(
    parameter int WIDTH = mod_exp_pkg::DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q, b_q, m_q, acc;
    logic [CW-1:0]    cnt;
    logic             running;
    logic [WIDTH:0]   dbl, sum, m_ext;
    logic [WIDTH-1:0] dbl_r, p_next;

    // acc stays < m, so 2*acc and (2*acc mod m) + b both fit in WIDTH+1 bits.
    always_comb begin
        m_ext  = {1'b0, m_q};
        dbl    = {acc, 1'b0};
        dbl_r  = (dbl >= m_ext) ? WIDTH'(dbl - m_ext) : WIDTH'(dbl);
        sum    = {1'b0, dbl_r} + (a_q[WIDTH-1] ? {1'b0, b_q} : '0);
        p_next = (sum >= m_ext) ? WIDTH'(sum - m_ext) : WIDTH'(sum);
    end

    assign done = running && (cnt == CW'(1));
    assign p    = p_next;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            a_q     <= a;
            b_q     <= b;
            m_q     <= m;
            acc     <= '0;
            cnt     <= CW'(WIDTH);
            running <= 1'b1;
        end else if (running) begin
            acc <= p_next;
            a_q <= a_q << 1;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) running <= 1'b0;
        end
    end

endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiation built around one
// serial modular multiplier; c_out = (base^exponent) mod modulo.
module mod_exp_engine
    import mod_exp_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [WIDTH-1:0]     base_in,
    input  logic [EXP_WIDTH-1:0] exponent_in,
    input  logic [WIDTH-1:0]     modulo_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [WIDTH-1:0]     c_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 busy_out,
    output logic                 error_out
);

    state_t               state, state_nx;
    logic [WIDTH-1:0]     base_q, m_q, cur, prod, c_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic                 err_q, start_q, launch;
    logic [WIDTH-1:0]     mult_a, mult_b, mult_p;
    logic                 mult_done;

    mod_mult_serial #(.WIDTH(WIDTH)) u_mult (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start    (start_q),
        .a        (mult_a),
        .b        (mult_b),
        .m        (m_q),
        .done     (mult_done),
        .p        (mult_p)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nx;
    end

    // exp_q[0] is the bit being processed; it shifts right after every square.
    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        mult_a   = base_q;
        mult_b   = WIDTH'(1);
        unique case (state)
            IDLE: begin
                if (valid_in) begin
                    if (modulo_in == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = REDUCE;
                        launch   = 1'b1;
                    end
                end
            end
            REDUCE: begin
                if (mult_done) begin
                    if (exp_q == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = exp_q[0] ? MUL : SQR;
                        launch   = 1'b1;
                    end
                end
            end
            MUL: begin
                mult_a = prod;
                mult_b = cur;
                if (mult_done) begin
                    if (|exp_q[EXP_WIDTH-1:1]) begin
                        state_nx = SQR;
                        launch   = 1'b1;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            SQR: begin
                mult_a = cur;
                mult_b = cur;
                // A square is only issued when a higher 1 bit remains.
                if (mult_done) begin
                    state_nx = exp_q[1] ? MUL : SQR;
                    launch   = 1'b1;
                end
            end
            DONE: begin
                if (ready_in) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            base_q  <= '0;
            exp_q   <= '0;
            m_q     <= '0;
            cur     <= '0;
            prod    <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= launch;
            if (state == IDLE && valid_in) begin
                base_q <= base_in;
                exp_q  <= exponent_in;
                m_q    <= modulo_in;
                cur    <= '0;
                prod   <= (modulo_in == WIDTH'(1)) ? '0 : WIDTH'(1);
                err_q  <= (modulo_in == '0);
                c_q    <= '0;
            end
            if (mult_done) begin
                case (state)
                    REDUCE: cur <= mult_p;
                    MUL:    prod <= mult_p;
                    SQR: begin
                        cur   <= mult_p;
                        exp_q <= exp_q >> 1;
                    end
                    default: ;
                endcase
            end
            if (state != DONE && state_nx == DONE) begin
                c_q <= (state == MUL) ? mult_p : (state == REDUCE) ? prod : '0;
            end
            if (state == DONE && ready_in) begin
                c_q   <= '0;
                err_q <= 1'b0;
            end
        end
    end

    assign ready_out = (state == IDLE);
    assign valid_out = (state == DONE);
    assign busy_out  = (state == REDUCE) || (state == MUL) || (state == SQR);
    assign error_out = err_q && (state == DONE);
    assign c_out     = c_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Self-checking bench for mod_exp_engine at WIDTH = EXP_WIDTH = 16: directed
// cases, back-pressure, reset mid-operation and random operands vs a model.
module tb_mod_exp_engine;

    localparam int W      = 16;
    localparam int EW     = 16;
    localparam int BUDGET = 1500;

    logic clk;
    logic rst_n;

    mod_exp_engine_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();

    mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .base_in     (bus.base),
        .exponent_in (bus.exponent),
        .modulo_in   (bus.modulo),
        .valid_in    (bus.op_valid),
        .ready_out   (bus.op_ready),
        .c_out       (bus.c),
        .valid_out   (bus.res_valid),
        .ready_in    (bus.res_ready),
        .busy_out    (bus.busy),
        .error_out   (bus.error)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [W:0] exp_q[$];
    int         lat_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [EW-1:0] e,
                                                input logic [W-1:0] m);
        longint unsigned r, x, mm;
        if (m == '0) return '0;
        mm = longint'(m);
        r  = 1 % mm;
        x  = longint'(b) % mm;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return W'(r);
    endfunction

    // Cycle of valid_out relative to the accept cycle: 1 + ops*(W+1).
    function automatic int ref_latency(input logic [EW-1:0] e, input logic [W-1:0] m);
        int n, msb;
        if (m == '0) return 1;
        n   = 1;
        msb = 0;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) begin
                n++;
                msb = i;
            end
        end
        return 1 + (n + msb) * (W + 1);
    endfunction

    task automatic scramble_inputs();
        bus.base     = W'($urandom);
        bus.exponent = EW'($urandom);
        bus.modulo   = W'($urandom);
    endtask

    task automatic drive_op(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m);
        int waited = 0;
        while (bus.op_ready !== 1'b1 && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (bus.op_ready !== 1'b1) begin
            $display("FAIL accept_wait: ready_out=%b after %0d cycles, want 1", bus.op_ready, waited);
            miscompares++;
        end
        bus.base     = b;
        bus.exponent = e;
        bus.modulo   = m;
        bus.op_valid = 1'b1;
        exp_q.push_back({(m == '0), ref_modexp(b, e, m)});
        lat_q.push_back(ref_latency(e, m));
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        scramble_inputs();
        vectors++;
        if ({bus.op_ready, bus.busy} !== {1'b0, (m != '0)}) begin
            $display("FAIL cycle1_status: ready_out,busy_out=%b%b want %b%b",
                     bus.op_ready, bus.busy, 1'b0, (m != '0));
            miscompares++;
        end
    endtask

    task automatic collect_op(input int hold);
        int         cyc = 1;
        logic [W:0] want;
        int         want_lat;
        while (bus.res_valid !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        want     = exp_q.pop_front();
        want_lat = lat_q.pop_front();
        vectors++;
        if (bus.res_valid !== 1'b1) begin
            $display("FAIL result_timeout: valid_out=%b after %0d cycles, want 1", bus.res_valid, cyc);
            miscompares++;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        vectors++;
        if ({bus.error, bus.c} !== want) begin
            $display("FAIL result: error_out=%b c_out=%0d, want error_out=%b c_out=%0d",
                     bus.error, bus.c, want[W], want[W-1:0]);
            miscompares++;
        end
        vectors++;
        if (cyc != want_lat) begin
            $display("FAIL latency: valid_out at cycle %0d, want %0d", cyc, want_lat);
            miscompares++;
        end
        for (int i = 0; i < hold; i++) begin
            bus.op_valid = 1'b1;
            scramble_inputs();
            @(negedge clk);
            vectors++;
            if ({bus.res_valid, bus.op_ready, bus.error, bus.c} !== {1'b1, 1'b0, want}) begin
                $display("FAIL hold: valid_out=%b ready_out=%b error_out=%b c_out=%0d, want 1 0 %b %0d",
                         bus.res_valid, bus.op_ready, bus.error, bus.c, want[W], want[W-1:0]);
                miscompares++;
            end
        end
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        vectors++;
        if ({bus.op_ready, bus.res_valid} !== 2'b10) begin
            $display("FAIL handshake: ready_out=%b valid_out=%b, want 1 0", bus.op_ready, bus.res_valid);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b0;
        scramble_inputs();
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.op_ready, bus.res_valid, bus.busy, bus.error, bus.c} !== {4'b1000, W'(0)}) begin
            $display("FAIL reset_state: ready=%b valid=%b busy=%b error=%b c=%0d, want 1 0 0 0 0",
                     bus.op_ready, bus.res_valid, bus.busy, bus.error, bus.c);
            miscompares++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        drive_op(16'd4, 16'd13, 16'd497);      collect_op(0);
        drive_op(16'd100, 16'd3, 16'd7);       collect_op(0);
        drive_op(16'd7, 16'd0, 16'd13);        collect_op(0);
        drive_op(16'd123, 16'd5, 16'd0);       collect_op(0);
        drive_op(16'd5, 16'd9, 16'd1);         collect_op(0);
        drive_op(16'd12345, 16'd54321, 16'hFFFF); collect_op(1);
        drive_op(16'hFFFF, 16'h8001, 16'hFFFF);   collect_op(0);
    endtask

    task automatic test_backpressure();
        drive_op(16'd3, 16'd5, 16'd11);
        collect_op(10);
    endtask

    task automatic test_reset_mid_op();
        drive_op(16'd3, 16'hFFFF, 16'd65521);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.op_ready, bus.res_valid, bus.busy, bus.error, bus.c} !== {4'b1000, W'(0)}) begin
            $display("FAIL reset_mid_op: ready=%b valid=%b busy=%b error=%b c=%0d, want 1 0 0 0 0",
                     bus.op_ready, bus.res_valid, bus.busy, bus.error, bus.c);
            miscompares++;
        end
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive_op(16'd3, 16'hFFFF, 16'd65521);
        collect_op(0);
    endtask

    task automatic test_random();
        logic [W-1:0]  b, m;
        logic [EW-1:0] e;
        int            sel;
        for (int k = 0; k < 1000; k++) begin
            b   = W'($urandom_range(0, 65535));
            sel = $urandom_range(0, 19);
            if (sel == 0)      m = '0;
            else if (sel == 1) m = W'(1);
            else if (sel == 2) m = 16'hFFFF;
            else               m = W'($urandom_range(2, 65535));
            if (k % 64 == 0) e = 16'h8000 | EW'($urandom_range(0, 32767));
            else             e = EW'($urandom_range(0, 3));
            drive_op(b, e, m);
            collect_op(k % 3);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
